// File: rtl/stream_demux_if.sv
// stream_demux_if: bundles the producer and consumer handshake signals of
// stream_demux.
//   master : the environment side. It drives em, a, s, a_valid and y_ready,
//            and it observes a_ready, y, y_valid and drop_cnt.
//   slave  : the demux side, with the directions reversed.
// Channel k data is carried on y[k*WIDTH +: WIDTH].
interface stream_demux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                      em;
    logic [WIDTH-1:0]          a;
    logic [SEL_W-1:0]          s;
    logic                      a_valid;
    logic                      a_ready;
    logic [CHANNELS*WIDTH-1:0] y;
    logic [CHANNELS-1:0]       y_valid;
    logic [CHANNELS-1:0]       y_ready;
    logic [7:0]                drop_cnt;

    modport master (
        output em, a, s, a_valid, y_ready,
        input  a_ready, y, y_valid, drop_cnt
    );

    modport slave (
        input  em, a, s, a_valid, y_ready,
        output a_ready, y, y_valid, drop_cnt
    );
endinterface

// File: rtl/stream_demux.sv
// stream_demux: registered 1:CHANNELS stream demultiplexer. Every channel has
// its own DEPTH-entry FIFO, so back-pressure on one consumer stalls only the
// words that are addressed to that consumer.
//
// Ports:
//   clk  : clock. All state updates on the rising edge.
//   rst  : synchronous, active-high reset. It clears all FIFOs and drop_cnt.
//   bus  : stream_demux_if.slave, which carries the following signals.
//     em       : enable. When 0, no words are accepted, but buffered words still drain.
//     a, s     : input word and destination channel index.
//     a_valid  : producer has a word. a_ready shows the word is accepted this cycle.
//     y        : channel k head at [k*WIDTH +: WIDTH]. It is 0 when the channel is empty.
//     y_valid  : channel k holds at least one word.
//     y_ready  : consumer k takes the head word.
//     drop_cnt : number of accepted words whose s was out of range.
//
// Optional feature, macro STREAM_DEMUX_DROP_CNT_EN:
//   Defined   : drop_cnt counts out-of-range words and saturates at 255.
//   Undefined : drop_cnt is tied to 0. Out-of-range words are still accepted
//               and discarded.

// Per-channel FIFO. The head output is taken from registered state only.
module stream_demux_chan #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop_rdy,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             pop;

    // Pointers wrap explicitly, so DEPTH does not have to be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid = (cnt != '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign pop   = valid && pop_rdy;
    assign dout  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            // When push and pop happen together, cnt holds its value.
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset. Entries are only observable through cnt.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= din;
    end
endmodule

module stream_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DEPTH    = 2
) (
    input  logic           clk,
    input  logic           rst,
    stream_demux_if.slave  bus
);
    logic [CHANNELS-1:0]            full;
    logic [CHANNELS-1:0]            push;
    logic [CHANNELS-1:0]            valid;
    logic [CHANNELS-1:0][WIDTH-1:0] dout;
    logic                           in_range;
    logic                           tgt_ok;
    logic                           accept;

    // A full target channel still accepts a word if that channel pops in the
    // same cycle. The pop frees the slot that the push fills.
    always_comb begin
        in_range = (32'(bus.s) < CHANNELS);
        tgt_ok   = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.s == SEL_W'(k)) tgt_ok = !full[k] || bus.y_ready[k];
        end
    end

    // a_ready depends on em, s, channel state and y_ready. It never depends on a_valid.
    assign bus.a_ready = bus.em && (!in_range || tgt_ok);
    assign accept      = bus.a_valid && bus.a_ready;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign push[k] = accept && (bus.s == SEL_W'(k));

        stream_demux_chan #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .push    (push[k]),
            .din     (bus.a),
            .pop_rdy (bus.y_ready[k]),
            .full    (full[k]),
            .valid   (valid[k]),
            .dout    (dout[k])
        );
    end

    assign bus.y       = dout;
    assign bus.y_valid = valid;

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst)
            drop_q <= '0;
        else if (accept && !in_range && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    stream_demux_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) bus4 ();
    stream_demux_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) bus3 ();

    stream_demux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DEPTH(2)) dut4 (
        .clk (clk), .rst (rst), .bus (bus4)
    );
    stream_demux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DEPTH(2)) dut3 (
        .clk (clk), .rst (rst), .bus (bus3)
    );

    typedef struct {
        logic       rst;
        logic       em;
        logic       av;
        logic [7:0] a;
        logic [1:0] s;
        logic [3:0] yr;
        logic       exp_rdy;
        logic [3:0] exp_yv;
    } vec_t;

    vec_t tbl [25];

    // Scoreboard: per-channel queues of the words expected at each head.
    logic [7:0] q [4][$];

    function automatic vec_t mk(input logic r, input logic e, input logic v,
                                input logic [7:0] a, input logic [1:0] s,
                                input logic [3:0] yr, input logic er,
                                input logic [3:0] ey);
        vec_t t;
        t.rst = r; t.em = e; t.av = v; t.a = a; t.s = s; t.yr = yr;
        t.exp_rdy = er; t.exp_yv = ey;
        return t;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int row);
        logic mrdy;
        rst          = v.rst;
        bus4.em      = v.em;
        bus4.a_valid = v.av;
        bus4.a       = v.a;
        bus4.s       = v.s;
        bus4.y_ready = v.yr;
        @(negedge clk);
        cmp($sformatf("row%0d a_ready", row), 32'(bus4.a_ready), 32'(v.exp_rdy));
        cmp($sformatf("row%0d y_valid", row), 32'(bus4.y_valid), 32'(v.exp_yv));
        mrdy = v.em && (q[v.s].size() < 2 || v.yr[v.s]);
        cmp($sformatf("row%0d a_ready_model", row), 32'(bus4.a_ready), 32'(mrdy));
        for (int k = 0; k < 4; k++) begin
            cmp($sformatf("row%0d y[%0d]", row, k), 32'(bus4.y[k*8 +: 8]),
                32'((q[k].size() != 0) ? q[k][0] : 8'h00));
        end
        cmp($sformatf("row%0d drop_cnt", row), 32'(bus4.drop_cnt), 32'd0);
        if (v.rst) begin
            for (int k = 0; k < 4; k++) q[k].delete();
        end else begin
            for (int k = 0; k < 4; k++)
                if (q[k].size() != 0 && v.yr[k]) void'(q[k].pop_front());
            if (v.av && mrdy) q[v.s].push_back(v.a);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus4.em = 1'b0; bus4.a_valid = 1'b0; bus4.a = '0; bus4.s = '0; bus4.y_ready = '0;
        bus3.em = 1'b0; bus3.a_valid = 1'b0; bus3.a = '0; bus3.s = '0; bus3.y_ready = '0;

        // Each row lists rst, em, a_valid, a, s, y_ready, expected a_ready and
        // expected y_valid. Both expectations are sampled before that row's clock edge.
        tbl[0]  = mk(1, 1, 0, 8'h00, 0, 4'b0000, 1, 4'b0000);
        tbl[1]  = mk(1, 1, 0, 8'h00, 0, 4'b0000, 1, 4'b0000);
        tbl[2]  = mk(0, 1, 1, 8'hA5, 2, 4'b0000, 1, 4'b0000);
        tbl[3]  = mk(0, 1, 0, 8'h00, 0, 4'b0000, 1, 4'b0100);
        tbl[4]  = mk(0, 1, 1, 8'h11, 1, 4'b0000, 1, 4'b0100);
        tbl[5]  = mk(0, 1, 1, 8'h22, 1, 4'b0000, 1, 4'b0110);
        tbl[6]  = mk(0, 1, 1, 8'h33, 1, 4'b0000, 0, 4'b0110);
        tbl[7]  = mk(0, 1, 1, 8'h44, 0, 4'b0000, 1, 4'b0110);
        tbl[8]  = mk(0, 1, 1, 8'h33, 1, 4'b0010, 1, 4'b0111);
        tbl[9]  = mk(0, 1, 0, 8'h00, 0, 4'b0010, 1, 4'b0111);
        tbl[10] = mk(0, 1, 0, 8'h00, 0, 4'b0010, 1, 4'b0111);
        tbl[11] = mk(0, 1, 0, 8'h00, 0, 4'b0000, 1, 4'b0101);
        tbl[12] = mk(0, 1, 1, 8'h01, 3, 4'b0000, 1, 4'b0101);
        tbl[13] = mk(0, 1, 1, 8'h02, 3, 4'b0000, 1, 4'b1101);
        tbl[14] = mk(0, 1, 1, 8'h03, 3, 4'b1000, 1, 4'b1101);
        tbl[15] = mk(0, 1, 0, 8'h00, 0, 4'b0000, 1, 4'b1101);
        tbl[16] = mk(0, 1, 1, 8'h04, 3, 4'b0000, 0, 4'b1101);
        tbl[17] = mk(0, 1, 1, 8'h55, 0, 4'b0000, 1, 4'b1101);
        tbl[18] = mk(0, 0, 1, 8'h66, 0, 4'b0000, 0, 4'b1101);
        tbl[19] = mk(0, 0, 1, 8'h66, 2, 4'b0001, 0, 4'b1101);
        tbl[20] = mk(0, 0, 1, 8'h66, 0, 4'b0001, 0, 4'b1101);
        tbl[21] = mk(0, 0, 0, 8'h00, 0, 4'b0000, 0, 4'b1100);
        tbl[22] = mk(1, 1, 1, 8'h77, 1, 4'b1111, 1, 4'b1100);
        tbl[23] = mk(0, 1, 0, 8'h00, 0, 4'b0000, 1, 4'b0000);
        tbl[24] = mk(0, 0, 0, 8'h00, 0, 4'b0000, 0, 4'b0000);

        for (int i = 0; i < 25; i++) step(tbl[i], i);

        // Out-of-range select on the 3-channel instance: s=3 is accepted and
        // then discarded.
        bus3.em = 1'b1; bus3.a_valid = 1'b1; bus3.s = 2'd3;
        for (int i = 0; i < 5; i++) begin
            bus3.a = 8'(i + 1);
            @(negedge clk);
            cmp($sformatf("oor%0d a_ready", i), 32'(bus3.a_ready), 32'd1);
            cmp($sformatf("oor%0d y_valid", i), 32'(bus3.y_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        bus3.a_valid = 1'b0;
        @(negedge clk);
        cmp("oor drop_cnt=5", 32'(bus3.drop_cnt), DROP_EN ? 32'd5 : 32'd0);
        cmp("oor y zero", 32'(bus3.y), 32'd0);

        // Saturation: 5 + 260 drops must stop at 255.
        @(posedge clk); #1;
        bus3.a_valid = 1'b1;
        repeat (260) @(posedge clk);
        #1;
        bus3.a_valid = 1'b0;
        @(negedge clk);
        cmp("drop_cnt saturate", 32'(bus3.drop_cnt), DROP_EN ? 32'd255 : 32'd0);

        // In-range word on the 3-channel instance is still delivered after the drops.
        @(posedge clk); #1;
        bus3.a_valid = 1'b1; bus3.s = 2'd0; bus3.a = 8'h3C;
        @(posedge clk); #1;
        bus3.a_valid = 1'b0;
        @(negedge clk);
        cmp("dut3 y_valid ch0", 32'(bus3.y_valid), 32'b001);
        cmp("dut3 y ch0", 32'(bus3.y), 32'h3C);

        // Reset clears the counter and the buffered word.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        cmp("post-rst drop_cnt", 32'(bus3.drop_cnt), 32'd0);
        cmp("post-rst y_valid", 32'(bus3.y_valid), 32'd0);
        cmp("post-rst y", 32'(bus3.y), 32'd0);
        cmp("post-rst a_ready=em", 32'(bus3.a_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
